// File: rtl/wb_multi_pkg.sv
// wb_multi_pkg: shared widths, stall encoding and lane/trace record layouts for the writeback stage
package wb_multi_pkg;
  localparam int StallBus = 6;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } wb_lane_t;
  typedef struct packed {
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
  } hilo_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_t;
  localparam int WB_LANE_WD = $bits(wb_lane_t);
  localparam int HILO_WD = $bits(hilo_t);
  localparam int RF_LANE_WD = 38;
  function automatic trace_t to_trace(input wb_lane_t l);
    return '{pc: l.pc, we: l.rf_we, wnum: l.rf_waddr, wdata: l.rf_wdata};
  endfunction
endpackage

// File: rtl/wb_multi_if.sv
// wb_multi_if: memory-to-writeback inputs, register-file writeback bus and serialized debug trace port
interface wb_multi_if import wb_multi_pkg::*; #(
  parameter int LANES = 2
);
  logic [StallBus-1:0]                 stall;
  logic                                flush;
  logic [LANES*WB_LANE_WD-1:0]         mem_to_wb_bus;
  logic [HILO_WD-1:0]                  mem_to_wb_hilo;
  logic [LANES*RF_LANE_WD+HILO_WD-1:0] wb_to_rf_bus;
  logic [31:0]                         debug_wb_pc;
  logic [3:0]                          debug_wb_rf_wen;
  logic [4:0]                          debug_wb_rf_wnum;
  logic [31:0]                         debug_wb_rf_wdata;
  logic                                stallreq_wb;
  logic                                trace_overflow;
  modport master (
    output stall, flush, mem_to_wb_bus, mem_to_wb_hilo,
    input  wb_to_rf_bus, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  stallreq_wb, trace_overflow
  );
  modport slave (
    input  stall, flush, mem_to_wb_bus, mem_to_wb_hilo,
    output wb_to_rf_bus, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output stallreq_wb, trace_overflow
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: circular trace queue taking up to LANES compacted entries per cycle and yielding one
module wb_trace_fifo import wb_multi_pkg::*; #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic [AW:0] push_cnt,
  input  trace_t  push_data [LANES],
  input  logic    pop,
  output trace_t  pop_data,
  output logic [AW:0] occ,
  output logic [AW:0] free
);
  trace_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] acc;
  logic do_pop;
  assign free = (AW+1)'(DEPTH) - occ;
  // entries beyond the free space are simply not written; the caller flags the loss
  assign acc = push_cnt > free ? free : push_cnt;
  assign do_pop = pop && occ != '0;
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (!rst && i < int'(acc)) mem[wr_ptr + AW'(i)] <= push_data[i];
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      wr_ptr <= wr_ptr + acc[AW-1:0];
      rd_ptr <= rd_ptr + AW'(do_pop);
      occ <= occ + acc - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wb_multi.sv
// wb_multi: multi-lane writeback stage register with RF writeback bus and a serialized debug trace
module wb_multi import wb_multi_pkg::*; #(
  parameter int LANES = 2,
  parameter int TRACE_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  wb_multi_if.slave wb
);
  localparam int AW = $clog2(TRACE_DEPTH);
  wb_lane_t [LANES-1:0] lane_in, stage_q;
  hilo_t hilo_q;
  logic fresh, load, bubble, pop;
  logic [LANES*RF_LANE_WD-1:0] rf_lanes;
  trace_t push_data [LANES];
  trace_t pop_data;
  logic [AW:0] push_cnt, occ, free;
  assign lane_in = wb.mem_to_wb_bus;
  assign load = wb.stall[4] == NoStop;
  assign bubble = wb.stall[4] == Stop && wb.stall[5] == NoStop;
  always_ff @(posedge clk) begin
    if (rst || wb.flush || bubble) begin
      stage_q <= '0;
      hilo_q <= '0;
    end else if (load) begin
      stage_q <= lane_in;
      hilo_q <= wb.mem_to_wb_hilo;
    end
    fresh <= !rst && !wb.flush && load;
  end
  always_comb begin
    rf_lanes = '0;
    for (int i = 0; i < LANES; i++)
      rf_lanes[i*RF_LANE_WD +: RF_LANE_WD] = {stage_q[i].rf_we & stage_q[i].valid, stage_q[i].rf_waddr, stage_q[i].rf_wdata};
  end
  assign wb.wb_to_rf_bus = {hilo_q, rf_lanes};
  // valid lanes are packed to the front so the queue keeps ascending lane order
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < LANES; i++) push_data[i] = '0;
    for (int i = 0; i < LANES; i++)
      if (fresh && stage_q[i].valid) begin
        push_data[k] = to_trace(stage_q[i]);
        k++;
      end
    push_cnt = (AW+1)'(k);
  end
  assign pop = occ != '0;
  wb_trace_fifo #(.LANES(LANES), .DEPTH(TRACE_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_cnt(push_cnt),
    .push_data(push_data),
    .pop(pop),
    .pop_data(pop_data),
    .occ(occ),
    .free(free)
  );
  assign wb.stallreq_wb = occ > (AW+1)'(TRACE_DEPTH - 2*LANES);
  always_ff @(posedge clk) begin
    if (rst) begin
      wb.debug_wb_pc <= '0;
      wb.debug_wb_rf_wen <= '0;
      wb.debug_wb_rf_wnum <= '0;
      wb.debug_wb_rf_wdata <= '0;
      wb.trace_overflow <= 1'b0;
    end else begin
      if (pop) begin
        wb.debug_wb_pc <= pop_data.pc;
        wb.debug_wb_rf_wen <= {4{pop_data.we}};
        wb.debug_wb_rf_wnum <= pop_data.wnum;
        wb.debug_wb_rf_wdata <= pop_data.wdata;
      end else
        wb.debug_wb_rf_wen <= '0;
      if (push_cnt > free) wb.trace_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_multi.sv
// tb_wb_multi: directed scenarios plus random traffic against a queue-based reference of the writeback trace
module tb_wb_multi;
  import wb_multi_pkg::*;
  localparam int L = 2;
  localparam int D = 8;
  localparam int RW = L*38 + 66;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] in_stall;
  logic in_flush;
  logic [70:0] in_lane [L];
  logic [65:0] in_hilo;
  int checks = 0;
  int errors = 0;
  logic [70:0] m_lane [L];
  logic [65:0] m_hilo;
  logic m_fresh, m_ovf;
  logic [69:0] q[$];
  logic [31:0] m_pc, m_wdata;
  logic [3:0] m_wen;
  logic [4:0] m_wnum;
  logic [31:0] obs[$];

  always #5 clk = ~clk;

  wb_multi_if #(.LANES(L)) bus();
  wb_multi #(.LANES(L), .TRACE_DEPTH(D)) dut (.clk(clk), .rst(rst), .wb(bus));

  assign bus.stall = in_stall;
  assign bus.flush = in_flush;
  assign bus.mem_to_wb_hilo = in_hilo;
  assign bus.mem_to_wb_bus = {in_lane[1], in_lane[0]};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_at(input int i);
    return obs.size() > i ? obs[i] : 32'hdead_beef;
  endfunction

  task automatic check_all();
    logic [RW-1:0] e;
    e[RW-1 -: 66] = m_hilo;
    for (int i = 0; i < L; i++) e[i*38 +: 38] = {m_lane[i][70] & m_lane[i][37], m_lane[i][36:0]};
    chk("rf_bus", bus.wb_to_rf_bus, e);
    chk("stallreq", bus.stallreq_wb, q.size() > D - 2*L);
    chk("dbg_wen", bus.debug_wb_rf_wen, m_wen);
    chk("dbg_pc", bus.debug_wb_pc, m_pc);
    chk("dbg_wnum", bus.debug_wb_rf_wnum, m_wnum);
    chk("dbg_wdata", bus.debug_wb_rf_wdata, m_wdata);
    chk("overflow", bus.trace_overflow, m_ovf);
    if (bus.debug_wb_rf_wen != 4'h0) obs.push_back(bus.debug_wb_pc);
  endtask

  // one clock edge of the reference: pop oldest, append fitting valid lanes, then update the stage
  task automatic model_edge();
    logic [69:0] cand[$];
    logic [69:0] head;
    bit do_pop;
    int free;
    do_pop = q.size() != 0;
    head = do_pop ? q[0] : '0;
    if (m_fresh)
      for (int i = 0; i < L; i++) if (m_lane[i][70]) cand.push_back(m_lane[i][69:0]);
    free = D - q.size();
    if (cand.size() > free) begin
      m_ovf = 1'b1;
      while (cand.size() > free) void'(cand.pop_back());
    end
    if (do_pop) void'(q.pop_front());
    foreach (cand[i]) q.push_back(cand[i]);
    if (do_pop) begin
      m_pc = head[69:38];
      m_wen = {4{head[37]}};
      m_wnum = head[36:32];
      m_wdata = head[31:0];
    end else m_wen = 4'h0;
    if (rst || in_flush || (in_stall[4] && !in_stall[5])) begin
      for (int i = 0; i < L; i++) m_lane[i] = '0;
      m_hilo = '0;
    end else if (!in_stall[4]) begin
      for (int i = 0; i < L; i++) m_lane[i] = in_lane[i];
      m_hilo = in_hilo;
    end
    m_fresh = !rst && !in_flush && !in_stall[4];
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_pc = '0;
      m_wen = '0;
      m_wnum = '0;
      m_wdata = '0;
    end
  endtask

  task automatic edge_only();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    check_all();
    edge_only();
  endtask

  task automatic set_lane(input int i, input logic v, input logic [31:0] pc, input logic we);
    in_lane[i] = {v, pc, we, pc[6:2], ~pc};
  endtask

  task automatic set2(input logic [31:0] pc0, input logic [31:0] pc1);
    set_lane(0, 1'b1, pc0, 1'b1);
    set_lane(1, 1'b1, pc1, 1'b1);
    in_stall = '0;
    in_flush = 1'b0;
  endtask

  task automatic idle();
    set_lane(0, 1'b0, '0, 1'b0);
    set_lane(1, 1'b0, '0, 1'b0);
    in_stall = '0;
    in_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_hilo = '0;
    idle();
    edge_only();
    step();
    chk("rst_wen", bus.debug_wb_rf_wen, 4'h0);
    chk("rst_ovf", bus.trace_overflow, 1'b0);
    rst = 1'b0;
    // two lanes retire together, trace serializes them
    obs.delete();
    in_hilo = {1'b1, 32'h1111_0000, 1'b1, 32'h2222_0000};
    set2(32'h1000, 32'h1004);
    step();
    chk("s1_rf_we_both", {bus.wb_to_rf_bus[75], bus.wb_to_rf_bus[37]}, 2'b11);
    in_hilo = '0;
    idle();
    repeat (5) step();
    chk("s1_count", obs.size(), 2);
    chk("s1_first", obs_at(0), 32'h1000);
    chk("s1_second", obs_at(1), 32'h1004);
    // bubble
    obs.delete();
    set2(32'h2000, 32'h2004);
    in_stall = 6'b010000;
    step();
    chk("s2_rf_zero", bus.wb_to_rf_bus, '0);
    idle();
    repeat (4) step();
    chk("s2_no_trace", obs.size(), 0);
    // hold for three cycles
    obs.delete();
    idle();
    set_lane(0, 1'b1, 32'h3000, 1'b1);
    step();
    set_lane(0, 1'b1, 32'h3100, 1'b1);
    in_stall = 6'b110000;
    repeat (3) step();
    chk("s3_held_we", bus.wb_to_rf_bus[37], 1'b1);
    idle();
    repeat (5) step();
    chk("s3_count", obs.size(), 1);
    chk("s3_pc", obs_at(0), 32'h3000);
    // four 2-lane loads fill to occupancy 5
    obs.delete();
    for (int k = 0; k < 4; k++) begin
      set2(32'h4000 + 32'(8*k), 32'h4004 + 32'(8*k));
      step();
    end
    idle();
    chk("s4_stallreq_occ4", bus.stallreq_wb, 1'b0);
    step();
    chk("s4_stallreq_occ5", bus.stallreq_wb, 1'b1);
    repeat (12) step();
    chk("s4_count", obs.size(), 8);
    for (int k = 0; k < 8; k++) chk("s4_order", obs_at(k), 32'h4000 + 32'(4*k));
    chk("s4_no_ovf", bus.trace_overflow, 1'b0);
    // ignore stallreq until the queue overflows
    obs.delete();
    for (int k = 0; k < 7; k++) begin
      set2(32'h5000 + 32'(8*k), 32'h5004 + 32'(8*k));
      step();
    end
    idle();
    step();
    chk("s5_ovf", bus.trace_overflow, 1'b1);
    repeat (12) step();
    chk("s5_ovf_sticky", bus.trace_overflow, 1'b1);
    chk("s5_count", obs.size(), 13);
    chk("s5_last_lane0", obs_at(12), 32'h5030);
    // flush keeps queue, reset discards it
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs.delete();
    set2(32'h6000, 32'h6004);
    step();
    set2(32'h6010, 32'h6014);
    step();
    idle();
    step();
    in_flush = 1'b1;
    step();
    chk("s6_flush_keeps", bus.debug_wb_rf_wen, 4'hf);
    chk("s6_flush_rf", bus.wb_to_rf_bus, '0);
    in_flush = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_rst_wen", bus.debug_wb_rf_wen, 4'h0);
    chk("s6_rst_pc", bus.debug_wb_pc, 32'h0);
    chk("s6_rst_ovf", bus.trace_overflow, 1'b0);
    chk("s6_rst_stallreq", bus.stallreq_wb, 1'b0);
    repeat (2) step();
    chk("s6_drained", bus.debug_wb_rf_wen, 4'h0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(0, 63) == 0;
      in_flush = $urandom_range(0, 15) == 0;
      in_stall = {$urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 4'($urandom)};
      in_hilo = {1'($urandom), $urandom, 1'($urandom), $urandom};
      for (int i = 0; i < L; i++)
        in_lane[i] = {$urandom_range(0, 3) != 0, $urandom, 1'($urandom), 5'($urandom), $urandom};
      step();
    end
    rst = 1'b0;
    idle();
    repeat (12) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
